// File: rtl/dac_serializer_if.sv
// Sample handshake between the codec controller and the DAC serializer.
// A pair transfers on a cycle where sample_valid and sample_ready are both high.
interface dac_serializer_if;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/dac_serializer.sv
// Left-justified stereo serializer for the WM8731 DAC port.
// Divides clk into m_clk/b_clk/dac_lr_clk and shifts 32-bit frames out MSB-first.
module dac_serializer #(
    parameter int unsigned MCLK_DIV = 2,
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    dac_serializer_if.slave  smp,
    output logic             m_clk,
    output logic             b_clk,
    output logic             dac_lr_clk,
    output logic             dacdat,
    output logic             frame_start,
    output logic             underrun
);

    localparam int unsigned MW = $clog2(MCLK_DIV + 1);
    localparam int unsigned DW = $clog2(BCLK_DIV);
    localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BCLK_DIV - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] mcnt_q;
    logic          mclk_q;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic          bclk_q, bclk_d;
    logic          lr_q, lr_d;
    logic          dat_q, dat_d;
    logic [31:0]   shift_q, shift_d;
    logic [31:0]   buf_q, buf_d;
    logic          full_q, full_d;
    logic          fs_q, fs_d;
    logic          ur_q, ur_d;
    logic          accept;

    assign accept           = smp.sample_valid & ~full_q;
    assign smp.sample_ready = ~full_q;
    assign m_clk            = mclk_q;
    assign b_clk            = bclk_q;
    assign dac_lr_clk       = lr_q;
    assign dacdat           = dat_q;
    assign frame_start      = fs_q;
    assign underrun         = ur_q;

    // m_clk runs regardless of state or en
    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_q <= '0;
            mclk_q <= 1'b0;
        end else if (mcnt_q == M_LAST) begin
            mcnt_q <= '0;
            mclk_q <= ~mclk_q;
        end else begin
            mcnt_q <= mcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            bclk_q  <= 1'b0;
            lr_q    <= 1'b0;
            dat_q   <= 1'b0;
            shift_q <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            bclk_q  <= bclk_d;
            lr_q    <= lr_d;
            dat_q   <= dat_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        bclk_d  = bclk_q;
        lr_d    = lr_q;
        dat_d   = dat_q;
        shift_d = shift_q;
        buf_d   = accept ? {smp.sample_l, smp.sample_r} : buf_q;
        full_d  = full_q | accept;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bclk_d = 1'b0;
                lr_d   = 1'b0;
                dat_d  = 1'b0;
                if (en) begin
                    state_d = RUN;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            RUN: begin
                if (div_q != D_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (bclk_q) begin
                        bclk_d = 1'b0;
                    end else if (bit_q != 5'd0) begin
                        bclk_d  = 1'b1;
                        dat_d   = shift_q[31];
                        shift_d = {shift_q[30:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q == 5'd16) lr_d = 1'b0;
                    end else if (!en) begin
                        // frame boundary with en low: park, keep buffer
                        state_d = IDLE;
                        lr_d    = 1'b0;
                        dat_d   = 1'b0;
                    end else begin
                        bclk_d = 1'b1;
                        lr_d   = 1'b1;
                        fs_d   = 1'b1;
                        bit_d  = 5'd1;
                        if (full_q) begin
                            dat_d   = buf_q[31];
                            shift_d = {buf_q[30:0], 1'b0};
                            full_d  = 1'b0;
                        end else begin
                            dat_d   = 1'b0;
                            shift_d = '0;
                            ur_d    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Directed/random bench for dac_serializer with a frame-level reference model.
// A background consumer rebuilds frames on b_clk falling edges and checks them.
module tb_dac_serializer;

    localparam int MD = 2;
    localparam int BD = 4;
    localparam int FRAME = 64 * BD;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic m_clk, b_clk, dac_lr_clk, dacdat, frame_start, underrun;

    dac_serializer_if ifc ();

    dac_serializer #(
        .MCLK_DIV(MD),
        .BCLK_DIV(BD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .smp(ifc),
        .m_clk(m_clk),
        .b_clk(b_clk),
        .dac_lr_clk(dac_lr_clk),
        .dacdat(dacdat),
        .frame_start(frame_start),
        .underrun(underrun)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int unsigned c;
    } push_t;

    push_t       pq[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          frames_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return m_clk;
            1:       return b_clk;
            default: return dac_lr_clk;
        endcase
    endfunction

    // Consumer: a load takes the oldest sample accepted on an earlier edge
    initial begin
        logic        coll;
        logic        bprev;
        logic        expur;
        logic [31:0] expd, db, lb;
        int          nb;
        push_t       e;
        coll = 1'b0;
        bprev = 1'b0;
        expur = 1'b0;
        expd = '0;
        db = '0;
        lb = '0;
        nb = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                coll = 1'b0;
                bprev = 1'b0;
            end else begin
                if (frame_start) begin
                    if (pq.size() > 0 && pq[0].c < cyc) begin
                        e = pq.pop_front();
                        expd = e.d;
                        expur = 1'b0;
                    end else begin
                        expd = '0;
                        expur = 1'b1;
                    end
                    chk("underrun", 32'(underrun), 32'(expur));
                    coll = 1'b1;
                    nb = 0;
                    db = '0;
                    lb = '0;
                end
                if (coll && bprev && !b_clk) begin
                    db = {db[30:0], dacdat};
                    lb = {lb[30:0], dac_lr_clk};
                    nb++;
                    if (nb == 32) begin
                        chk("frame", db, expd);
                        chk("lr_duty", lb, 32'hFFFF0000);
                        coll = 1'b0;
                        frames_done++;
                    end
                end
                bprev = b_clk;
            end
        end
    end

    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        ifc.sample_l = d[31:16];
        ifc.sample_r = d[15:0];
        ifc.sample_valid = 1'b1;
        while (!ifc.sample_ready && n < 2000) begin
            tick();
            n++;
        end
        chk("push_timeout", 32'(n >= 2000), 32'd0);
        tick();
        if (n < 2000) pq.push_back('{d, cyc});
        ifc.sample_valid = 1'b0;
    endtask

    task automatic wait_fs(output int unsigned c);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 1000);
        chk("fs_timeout", 32'(n >= 1000), 32'd0);
        c = cyc;
    endtask

    task automatic wait_rises(input int k);
        int n, r;
        logic p;
        n = 0;
        r = 0;
        while (r < k && n < 2000) begin
            p = b_clk;
            tick();
            n++;
            if (!p && b_clk) r++;
        end
        chk("rise_timeout", 32'(n >= 2000), 32'd0);
    endtask

    task automatic first_rise(output int n);
        n = 0;
        while (!b_clk && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic measure(input int sel, output int per, output int hi);
        int n;
        logic p;
        n = 0;
        do begin
            p = sig(sel);
            tick();
            n++;
        end while (!(!p && sig(sel)) && n < 1000);
        hi = 0;
        do begin
            tick();
            hi++;
        end while (sig(sel) && hi < 1000);
        per = hi;
        do begin
            tick();
            per++;
        end while (!sig(sel) && per < 2000);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mclk"}, 32'(m_clk), 32'd0);
        chk({tag, "_bclk"}, 32'(b_clk), 32'd0);
        chk({tag, "_lr"}, 32'(dac_lr_clk), 32'd0);
        chk({tag, "_dat"}, 32'(dacdat), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_ur"}, 32'(underrun), 32'd0);
        chk({tag, "_ready"}, 32'(ifc.sample_ready), 32'd1);
    endtask

    initial begin
        int unsigned c0, c1;
        int          n, per, hi, fd0;
        logic [31:0] d;
        logic        any;

        reset = 1'b1;
        en = 1'b0;
        ifc.sample_valid = 1'b0;
        ifc.sample_l = '0;
        ifc.sample_r = '0;
        repeat (3) tick();
        chk_reset("rst");
        reset = 1'b0;

        push(32'hA5C31234);
        chk("ready_after_accept", 32'(ifc.sample_ready), 32'd0);
        repeat (10) tick();
        chk("idle_lines", 32'({b_clk, dac_lr_clk, dacdat}), 32'd0);
        chk("ready_held", 32'(ifc.sample_ready), 32'd0);
        en = 1'b1;
        first_rise(n);
        chk("first_rise", n, BD + 1);
        chk("fs_at_load", 32'(frame_start), 32'd1);
        chk("ready_after_load", 32'(ifc.sample_ready), 32'd1);
        c0 = cyc;

        for (int i = 0; i < 6; i++) begin
            if (i == 0) d = 32'h00018000;
            else if (i == 1) d = 32'hFFFF0000;
            else d = $urandom;
            push(d);
            wait_fs(c1);
            chk("frame_gap", c1 - c0, FRAME);
            c0 = c1;
        end

        wait_fs(c1);
        chk("underrun_gap", c1 - c0, FRAME);
        wait_fs(c1);
        measure(0, per, hi);
        chk("mclk_period", per, 2 * MD);
        chk("mclk_high", hi, MD);
        measure(1, per, hi);
        chk("bclk_period", per, 2 * BD);
        chk("bclk_high", hi, BD);
        measure(2, per, hi);
        chk("lr_period", per, FRAME);
        chk("lr_high", hi, FRAME / 2);

        wait_fs(c1);
        repeat (FRAME - 1) tick();
        d = $urandom;
        ifc.sample_l = d[31:16];
        ifc.sample_r = d[15:0];
        ifc.sample_valid = 1'b1;
        tick();
        chk("collide_fs", 32'(frame_start), 32'd1);
        chk("collide_ur", 32'(underrun), 32'd1);
        chk("collide_ready", 32'(ifc.sample_ready), 32'd0);
        pq.push_back('{d, cyc});
        ifc.sample_valid = 1'b0;
        wait_fs(c1);

        push($urandom);
        wait_fs(c1);
        push($urandom);
        wait_rises(5);
        en = 1'b0;
        fd0 = frames_done;
        repeat (230) tick();
        chk("frame_completed", frames_done, fd0 + 1);
        any = 1'b0;
        repeat (100) begin
            tick();
            any = any | b_clk | dac_lr_clk | dacdat | frame_start;
        end
        chk("idle_quiet", 32'(any), 32'd0);
        chk("pending_kept", 32'(ifc.sample_ready), 32'd0);

        en = 1'b1;
        first_rise(n);
        chk("reen_rise", n, BD + 1);
        chk("reen_fs", 32'(frame_start), 32'd1);
        chk("reen_ur", 32'(underrun), 32'd0);

        push($urandom);
        wait_rises(19);
        reset = 1'b1;
        en = 1'b0;
        tick();
        chk_reset("midrst");
        pq.delete();
        reset = 1'b0;
        en = 1'b1;
        first_rise(n);
        chk("rst_rise", n, BD + 1);
        chk("rst_fs", 32'(frame_start), 32'd1);
        chk("rst_ur", 32'(underrun), 32'd1);

        en = 1'b0;
        repeat (FRAME + 50) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
